apb_i2c_protocol_monitor: RTL and testbench

//  Synthesizable, parametrised APB + I2C-pin protocol monitor for the APB-to-I2C controller.

---
 rtl/apb_i2c_protocol_monitor.sv | 207 ++++++++++++++++++++
 tb/tb_apb_i2c_protocol_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_protocol_monitor.sv
// Passive APB slave-port and I2C-pad monitor: tracks APB phase order, latches sticky
// protocol violations, counts transfers/wait states and checks SDA/SCL drop after a disable write.
module apb_i2c_protocol_monitor #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int CTRL_ADDR = 4,
  parameter int EN_BIT    = 7,
  parameter int TIMEOUT   = 16,
  parameter int BUS_LAT   = 2,
  parameter int CNT_W     = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              sda_io,
  input  logic              scl_io,
  input  logic              clr_i,
  output logic              err_setup_o,
  output logic              err_stable_o,
  output logic              err_timeout_o,
  output logic              err_bus_o,
  output logic [CNT_W-1:0]  xfer_cnt_o,
  output logic [CNT_W-1:0]  wait_cnt_o,
  output logic [1:0]        state_o
);

  // Handshake: a transfer completes in the first ACCESS-state cycle with pready=1;
  // every ACCESS-state cycle with pready=0 is one wait state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(BUS_LAT + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic                cap_write_q, cap_write_d;
  logic [DATA_W-1:0]   cap_data_q, cap_data_d;
  logic [TW-1:0]       wait_ctr_q, wait_ctr_d;
  logic [TW-1:0]       wait_inc;
  logic [BW-1:0]       win_q, win_d;
  logic                err_setup_q, err_setup_d;
  logic                err_stable_q, err_stable_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_bus_q, err_bus_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic setup_ev, stable_ev, timeout_ev, bus_ev, xfer_ev, wait_ev, arm_ev;
  logic ctrl_changed;

  assign wait_inc = wait_ctr_q + TW'(1);

  // Only write data is held stable for a write; read data lines are don't-care.
  assign ctrl_changed = ~psel
                      | (paddr  != cap_addr_q)
                      | (pwrite != cap_write_q)
                      | (cap_write_q & (pwdata != cap_data_q));

  always_comb begin
    state_d     = state_q;
    cap_addr_d  = cap_addr_q;
    cap_write_d = cap_write_q;
    cap_data_d  = cap_data_q;
    wait_ctr_d  = wait_ctr_q;
    setup_ev    = 1'b0;
    stable_ev   = 1'b0;
    timeout_ev  = 1'b0;
    xfer_ev     = 1'b0;
    wait_ev     = 1'b0;
    arm_ev      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d     = ST_SETUP;
          cap_addr_d  = paddr;
          cap_write_d = pwrite;
          cap_data_d  = pwdata;
        end else if (psel && penable) begin
          setup_ev = 1'b1;
        end
      end
      ST_SETUP: begin
        if (psel && penable) begin
          state_d    = ST_ACCESS;
          wait_ctr_d = '0;
        end else begin
          setup_ev = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (pready) begin
          xfer_ev    = 1'b1;
          wait_ctr_d = '0;
          arm_ev     = cap_write_q && (cap_addr_q == ADDR_W'(CTRL_ADDR)) && !cap_data_q[EN_BIT];
          if (psel && !penable) begin
            state_d     = ST_SETUP;
            cap_addr_d  = paddr;
            cap_write_d = pwrite;
            cap_data_d  = pwdata;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          wait_ev   = 1'b1;
          stable_ev = ctrl_changed;
          if (wait_inc == TW'(TIMEOUT)) begin
            timeout_ev = 1'b1;
            state_d    = ST_IDLE;
            wait_ctr_d = '0;
          end else begin
            wait_ctr_d = wait_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Window counts the remaining sample cycles; a re-arm restarts it from BUS_LAT.
  always_comb begin
    win_d  = win_q;
    bus_ev = 1'b0;
    if (arm_ev) begin
      win_d = BW'(BUS_LAT);
    end else if (win_q != '0) begin
      if (!sda_io && !scl_io) begin
        win_d = '0;
      end else if (win_q == BW'(1)) begin
        bus_ev = 1'b1;
        win_d  = '0;
      end else begin
        win_d = win_q - BW'(1);
      end
    end
  end

  // A new event in the clear cycle still registers.
  always_comb begin
    err_setup_d   = setup_ev   | (~clr_i & err_setup_q);
    err_stable_d  = stable_ev  | (~clr_i & err_stable_q);
    err_timeout_d = timeout_ev | (~clr_i & err_timeout_q);
    err_bus_d     = bus_ev     | (~clr_i & err_bus_q);

    xfer_cnt_d = xfer_cnt_q;
    if (clr_i) begin
      xfer_cnt_d = xfer_ev ? CNT_W'(1) : '0;
    end else if (xfer_ev && !(&xfer_cnt_q)) begin
      xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
    end

    wait_cnt_d = wait_cnt_q;
    if (clr_i) begin
      wait_cnt_d = wait_ev ? CNT_W'(1) : '0;
    end else if (wait_ev && !(&wait_cnt_q)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q       <= ST_IDLE;
      cap_addr_q    <= '0;
      cap_write_q   <= 1'b0;
      cap_data_q    <= '0;
      wait_ctr_q    <= '0;
      win_q         <= '0;
      err_setup_q   <= 1'b0;
      err_stable_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_bus_q     <= 1'b0;
      xfer_cnt_q    <= '0;
      wait_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cap_addr_q    <= cap_addr_d;
      cap_write_q   <= cap_write_d;
      cap_data_q    <= cap_data_d;
      wait_ctr_q    <= wait_ctr_d;
      win_q         <= win_d;
      err_setup_q   <= err_setup_d;
      err_stable_q  <= err_stable_d;
      err_timeout_q <= err_timeout_d;
      err_bus_q     <= err_bus_d;
      xfer_cnt_q    <= xfer_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign err_setup_o   = err_setup_q;
  assign err_stable_o  = err_stable_q;
  assign err_timeout_o = err_timeout_q;
  assign err_bus_o     = err_bus_q;
  assign xfer_cnt_o    = xfer_cnt_q;
  assign wait_cnt_o    = wait_cnt_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_apb_i2c_protocol_monitor.sv
// Directed bench for apb_i2c_protocol_monitor: expected output snapshots are queued
// per step and compared field by field after the following clock edge.
module tb_apb_i2c_protocol_monitor;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;
  localparam int EW     = 4 + 2 * CNT_W + 2;

  logic              pclk;
  logic              preset;
  logic              psel, penable, pwrite, pready;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              sda_io, scl_io, clr_i;
  logic              err_setup_o, err_stable_o, err_timeout_o, err_bus_o;
  logic [CNT_W-1:0]  xfer_cnt_o, wait_cnt_o;
  logic [1:0]        state_o;

  logic [EW-1:0] exp_q[$];
  int total;
  int passed;
  int failed;

  apb_i2c_protocol_monitor #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CTRL_ADDR(4), .EN_BIT(7),
    .TIMEOUT(4), .BUS_LAT(2), .CNT_W(CNT_W)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .sda_io(sda_io), .scl_io(scl_io),
    .clr_i(clr_i), .err_setup_o(err_setup_o), .err_stable_o(err_stable_o),
    .err_timeout_o(err_timeout_o), .err_bus_o(err_bus_o), .xfer_cnt_o(xfer_cnt_o),
    .wait_cnt_o(wait_cnt_o), .state_o(state_o)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic cyc(input logic s, input logic e, input logic w, input logic [7:0] a,
                     input logic [7:0] d, input logic r, input logic sd, input logic sc,
                     input logic c);
    psel = s; penable = e; pwrite = w; paddr = a; pwdata = d; pready = r;
    sda_io = sd; scl_io = sc; clr_i = c;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n, input logic sd, input logic sc);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 8'h00, 0, sd, sc, 0);
  endtask

  task automatic clear();
    cyc(0, 0, 0, 8'h00, 8'h00, 0, 1, 1, 1);
  endtask

  task automatic apb_xfer(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input int nwait, input logic clr_last);
    cyc(1, 0, w, a, d, 0, 1, 1, 0);
    cyc(1, 1, w, a, d, 0, 1, 1, 0);
    for (int i = 0; i < nwait; i++) cyc(1, 1, w, a, d, 0, 1, 1, 0);
    cyc(1, 1, w, a, d, 1, 1, 1, clr_last);
  endtask

  // scoreboard
  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input logic es, input logic est, input logic eto, input logic eb,
                            input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] wc,
                            input logic [1:0] st);
    exp_q.push_back({es, est, eto, eb, x, wc, st});
  endtask

  task automatic check_out(input string tag);
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      failed++;
      $display("FAIL %s observed=empty-queue expected=entry", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".err_setup"},   16'(err_setup_o),   16'(e[EW-1]));
    cmp({tag, ".err_stable"},  16'(err_stable_o),  16'(e[EW-2]));
    cmp({tag, ".err_timeout"}, 16'(err_timeout_o), 16'(e[EW-3]));
    cmp({tag, ".err_bus"},     16'(err_bus_o),     16'(e[EW-4]));
    cmp({tag, ".xfer_cnt"},    16'(xfer_cnt_o),    16'(e[2*CNT_W+1:CNT_W+2]));
    cmp({tag, ".wait_cnt"},    16'(wait_cnt_o),    16'(e[CNT_W+1:2]));
    cmp({tag, ".state"},       16'(state_o),       16'(e[1:0]));
  endtask

  task automatic chk(input string tag, input logic es, input logic est, input logic eto,
                     input logic eb, input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] wc,
                     input logic [1:0] st);
    expect_out(es, est, eto, eb, x, wc, st);
    check_out(tag);
  endtask

  initial begin
    total = 0; passed = 0; failed = 0;
    preset = 1'b1;
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0; pready = 0;
    sda_io = 1; scl_io = 1; clr_i = 0;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;

    // plain write with enable set, no waits
    apb_xfer(1, 8'h04, 8'h80, 0, 0);
    idle(1, 1, 1);
    chk("write_en", 0, 0, 0, 0, 4'd1, 4'd0, 2'd0);

    // disable write, pins low in the 2nd cycle after completion
    apb_xfer(1, 8'h04, 8'h00, 0, 0);
    idle(1, 1, 1);
    idle(1, 0, 0);
    idle(1, 1, 1);
    chk("bus_pass", 0, 0, 0, 0, 4'd2, 4'd0, 2'd0);

    // disable write, pins stay high
    apb_xfer(1, 8'h04, 8'h00, 0, 0);
    idle(3, 1, 1);
    chk("bus_fail", 0, 0, 0, 1, 4'd3, 4'd0, 2'd0);

    clear();
    chk("clr_a", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);

    // read: pwdata moving during a wait is not a stability error
    cyc(1, 0, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h55, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h55, 1, 1, 1, 0);
    idle(1, 1, 1);
    chk("read_wdata", 0, 0, 0, 0, 4'd1, 4'd1, 2'd0);
    clear();

    // read with 3 waits, paddr changes in the 2nd wait
    cyc(1, 0, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h11, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h10, 8'h00, 1, 1, 1, 0);
    idle(1, 1, 1);
    chk("stable", 0, 1, 0, 0, 4'd1, 4'd3, 2'd0);
    clear();

    // timeout after the 4th wait
    cyc(1, 0, 0, 8'h20, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 0, 8'h20, 8'h00, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 8'h20, 8'h00, 0, 1, 1, 0);
    chk("to_pre", 0, 0, 0, 0, 4'd0, 4'd3, 2'd2);
    cyc(1, 1, 0, 8'h20, 8'h00, 0, 1, 1, 0);
    chk("to_hit", 0, 0, 1, 0, 4'd0, 4'd4, 2'd0);
    idle(2, 1, 1);
    apb_xfer(0, 8'h20, 8'h00, 0, 0);
    idle(1, 1, 1);
    chk("to_after", 0, 0, 1, 0, 4'd1, 4'd4, 2'd0);
    clear();
    chk("clr_b", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);

    // enable asserted straight from IDLE
    cyc(1, 1, 0, 8'h00, 8'h00, 0, 1, 1, 0);
    chk("setup_idle", 1, 0, 0, 0, 4'd0, 4'd0, 2'd0);
    idle(1, 1, 1);
    clear();
    chk("clr_c", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);

    // select dropped in SETUP
    cyc(1, 0, 0, 8'h08, 8'h00, 0, 1, 1, 0);
    cyc(0, 0, 0, 8'h08, 8'h00, 0, 1, 1, 0);
    chk("setup_drop", 1, 0, 0, 0, 4'd0, 4'd0, 2'd0);
    apb_xfer(0, 8'h08, 8'h00, 0, 0);
    chk("pre_clr_evt", 1, 0, 0, 0, 4'd1, 4'd0, 2'd0);
    apb_xfer(0, 8'h08, 8'h00, 0, 1);
    chk("clr_evt", 0, 0, 0, 0, 4'd1, 4'd0, 2'd0);
    clear();

    // back-to-back writes
    cyc(1, 0, 1, 8'h30, 8'h11, 0, 1, 1, 0);
    cyc(1, 1, 1, 8'h30, 8'h11, 0, 1, 1, 0);
    cyc(1, 0, 1, 8'h31, 8'h22, 1, 1, 1, 0);
    chk("b2b_mid", 0, 0, 0, 0, 4'd1, 4'd0, 2'd1);
    cyc(1, 1, 1, 8'h31, 8'h22, 0, 1, 1, 0);
    chk("b2b_acc", 0, 0, 0, 0, 4'd1, 4'd0, 2'd2);
    cyc(1, 1, 1, 8'h31, 8'h22, 1, 1, 1, 0);
    chk("b2b_end", 0, 0, 0, 0, 4'd2, 4'd0, 2'd0);
    idle(1, 1, 1);
    clear();

    // reset in ACCESS with a bus window open
    cyc(1, 0, 1, 8'h04, 8'h00, 0, 1, 1, 0);
    cyc(1, 1, 1, 8'h04, 8'h00, 0, 1, 1, 0);
    cyc(1, 0, 1, 8'h04, 8'h80, 1, 1, 1, 0);
    cyc(1, 1, 1, 8'h04, 8'h80, 0, 1, 1, 0);
    chk("pre_rst", 0, 0, 0, 0, 4'd1, 4'd0, 2'd2);
    #2;
    preset = 1'b1;
    #1;
    chk("rst_async", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);
    psel = 0; penable = 0; pready = 0;
    @(negedge pclk);
    preset = 1'b0;
    @(posedge pclk);
    #1;
    idle(3, 1, 1);
    chk("rst_win", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);

    // counter saturation
    for (int i = 0; i < 16; i++) apb_xfer(1, 8'h08, 8'h00, 1, 0);
    idle(1, 1, 1);
    chk("saturate", 0, 0, 0, 0, 4'd15, 4'd15, 2'd0);
    clear();
    chk("clr_sat", 0, 0, 0, 0, 4'd0, 4'd0, 2'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
